controlador: RTL and testbench



---
 rtl/controlador.sv | 55 +++++
 tb/tb_controlador.sv | 110 +++++++++++
 2 files changed

// File: rtl/controlador.sv
// controlador: microprogrammed vend sequencer for the coffee machine (8-word ROM, 3-bit uPC)
//   clk                   system clock, rising edge
//   rst                   asynchronous reset, active-low, forces uPC to 0
//   Condicion1..6         active-low conditions: coin, water, button, cancel, ready, timer
//   salida0..7            one-hot state outputs, salidaN high when uPC = N
module controlador (
   input  logic clk,
   input  logic rst,
   input  logic Condicion1,
   input  logic Condicion2,
   input  logic Condicion3,
   input  logic Condicion4,
   input  logic Condicion5,
   input  logic Condicion6,
   output logic salida0,
   output logic salida1,
   output logic salida2,
   output logic salida3,
   output logic salida4,
   output logic salida5,
   output logic salida6,
   output logic salida7
);
   typedef struct packed {
      logic [2:0] sel;
      logic [2:0] t_addr;
      logic [2:0] f_addr;
      logic [7:0] out;
   } uinst_t;
   logic [2:0] upc, upc_next;
   uinst_t     ui;
   logic [7:0] cond;
   always_comb begin
      ui = '0;
      case (upc)
         3'd0: ui = {3'd1, 3'd1, 3'd0, 8'b0000_0001};
         3'd1: ui = {3'd2, 3'd2, 3'd7, 8'b0000_0010};
         3'd2: ui = {3'd3, 3'd4, 3'd3, 8'b0000_0100};
         3'd3: ui = {3'd4, 3'd7, 3'd2, 8'b0000_1000};
         3'd4: ui = {3'd5, 3'd5, 3'd4, 8'b0001_0000};
         3'd5: ui = {3'd6, 3'd6, 3'd5, 8'b0010_0000};
         3'd6: ui = {3'd0, 3'd0, 3'd0, 8'b0100_0000};
         3'd7: ui = {3'd0, 3'd0, 3'd0, 8'b1000_0000};
         default: ui = '0;
      endcase
   end
   // select 0 is unconditional; inputs are inverted so a set bit means "condition true"
   assign cond = {1'b0, ~Condicion6, ~Condicion5, ~Condicion4,
                  ~Condicion3, ~Condicion2, ~Condicion1, 1'b1};
   assign upc_next = cond[ui.sel] ? ui.t_addr : ui.f_addr;
   always_ff @(posedge clk or negedge rst)
      if (!rst) upc <= 3'd0;
      else      upc <= upc_next;
   assign {salida7, salida6, salida5, salida4, salida3, salida2, salida1, salida0} = ui.out;
endmodule

// File: tb/tb_controlador.sv
// tb_controlador: directed-vector bench for the coffee-machine microsequencer
module tb_controlador;
   logic clk = 1'b0;
   logic rst;
   logic c1, c2, c3, c4, c5, c6;
   logic s0, s1, s2, s3, s4, s5, s6, s7;
   logic [7:0] outs;
   int vectors = 0;
   int errs = 0;
   controlador dut (
      .clk(clk), .rst(rst),
      .Condicion1(c1), .Condicion2(c2), .Condicion3(c3),
      .Condicion4(c4), .Condicion5(c5), .Condicion6(c6),
      .salida0(s0), .salida1(s1), .salida2(s2), .salida3(s3),
      .salida4(s4), .salida5(s5), .salida6(s6), .salida7(s7)
   );
   assign outs = {s7, s6, s5, s4, s3, s2, s1, s0};
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      vectors++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: outputs %b, expected %b", tag, got, exp);
      end
   endtask
   task automatic state_is(input string tag, input int s);
      chk(tag, outs, 8'd1 << s);
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic all_false();
      {c1, c2, c3, c4, c5, c6} = 6'b111111;
   endtask
   initial begin
      rst = 1'b0;
      all_false();
      tick();
      tick();
      state_is("reset_hold", 0);
      c1 = 1'b0;
      tick();
      state_is("reset_ignores_c1", 0);
      c2 = 1'b0;
      rst = 1'b1;
      // full vend
      tick(); state_is("vend_e1", 1);
      tick(); state_is("vend_e2", 2);
      c3 = 1'b0; c1 = 1'b1;
      tick(); state_is("vend_e3", 4);
      tick(); state_is("vend_e4", 4);
      c5 = 1'b0; c6 = 1'b0;
      tick(); state_is("vend_e5", 5);
      tick(); state_is("vend_e6", 6);
      tick(); state_is("vend_e7", 0);
      all_false();
      // no water
      c1 = 1'b0;
      tick(); state_is("nowater_s1", 1);
      c1 = 1'b1;
      tick(); state_is("nowater_s7", 7);
      tick(); state_is("nowater_s0", 0);
      tick(); state_is("nowater_idle", 0);
      // cancel
      c1 = 1'b0; c2 = 1'b0;
      tick(); state_is("cancel_s1", 1);
      tick(); state_is("cancel_s2", 2);
      all_false();
      tick(); state_is("cancel_alt_s3a", 3);
      tick(); state_is("cancel_alt_s2", 2);
      tick(); state_is("cancel_alt_s3b", 3);
      c4 = 1'b0;
      tick(); state_is("cancel_s7", 7);
      c4 = 1'b1;
      tick(); state_is("cancel_s0", 0);
      // stall in heating, other conditions active but ignored
      c1 = 1'b0; c2 = 1'b0; c3 = 1'b0;
      tick(); tick(); tick();
      state_is("stall_enter_s4", 4);
      c1 = 1'b0; c3 = 1'b0; c4 = 1'b0; c6 = 1'b0; c2 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         state_is($sformatf("stall_s4_%0d", i), 4);
      end
      c5 = 1'b0; c6 = 1'b1;
      tick(); state_is("stall_to_s5", 5);
      all_false();
      for (int i = 0; i < 3; i++) begin
         tick();
         state_is($sformatf("hold_s5_%0d", i), 5);
      end
      // asynchronous abort from S5, checked before any clock edge
      #3 rst = 1'b0;
      #1 state_is("async_reset_s5", 0);
      tick();
      state_is("async_reset_held", 0);
      rst = 1'b1;
      // idle with C2..C6 toggling
      for (int i = 0; i < 20; i++) begin
         {c2, c3, c4, c5, c6} = 5'(i * 7);
         c1 = 1'b1;
         tick();
         state_is($sformatf("idle_%0d", i), 0);
      end
      all_false();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
